// File: rtl/id_pkg.sv
// id_pkg: opcode map, format classes and the decoded-field
// bundle shared by the decode queue and its immediate decoder.
package id_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } id_fields_t;

    function automatic id_fields_t pack_fields(
        input logic [31:0] inst,
        input fmt_e        fmt,
        input logic        illegal
    );
        id_fields_t f;
        f.opcode  = inst[6:0];
        f.rd      = inst[11:7];
        f.funct3  = inst[14:12];
        f.rs1     = inst[19:15];
        f.rs2     = inst[24:20];
        f.funct7  = inst[31:25];
        f.fmt     = fmt;
        f.illegal = illegal;
        return f;
    endfunction

endpackage

// File: rtl/id_decode_queue_if.sv
// id_decode_queue_if: fetch-side and issue-side handshake bundle
// of the decode queue, with queue (slave) and driver (master) views.
interface id_decode_queue_if #(
    parameter int XLEN = 32
) ();

    logic            ifid_valid;
    logic            ifid_ready;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_inst;
    logic            flush;
    logic            idsue_valid;
    logic            idsue_ready;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    modport master (
        output ifid_valid, ifid_pc, ifid_inst, flush, idsue_ready,
        input  ifid_ready, idsue_valid, pc, opcode, rd, funct3,
        input  rs1, rs2, funct7, imm, fmt, illegal
    );

    modport slave (
        input  ifid_valid, ifid_pc, ifid_inst, flush, idsue_ready,
        output ifid_ready, idsue_valid, pc, opcode, rd, funct3,
        output rs1, rs2, funct7, imm, fmt, illegal
    );

endinterface

// File: rtl/id_imm_gen.sv
// id_imm_gen: combinational RV32I/RV64I immediate, format
// and legality decoder for one raw instruction word.
module id_imm_gen
    import id_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [31:0] imm32;
    logic        s;

    assign s = inst_i[31];

    // Every opcode ends in 2'b11, so an exact match also rejects
    // compressed encodings.
    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_I;
        illegal_o = 1'b0;
        unique case (inst_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {inst_i[31:12], 12'h000};
                fmt_o = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{12{s}}, inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
                fmt_o = FMT_J;
            end
            OPC_BRANCH: begin
                imm32 = {{20{s}}, inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
                fmt_o = FMT_B;
            end
            OPC_STORE: begin
                imm32 = {{20{s}}, inst_i[31:25], inst_i[11:7]};
                fmt_o = FMT_S;
            end
            OPC_OP_IMM, OPC_JALR, OPC_LOAD,
            OPC_MISC_MEM, OPC_SYSTEM: begin
                imm32 = {{20{s}}, inst_i[31:20]};
            end
            OPC_OP: begin
                fmt_o = FMT_R;
            end
            OPC_OP_IMM_32: begin
                if (RV64) imm32 = {{20{s}}, inst_i[31:20]};
                else      illegal_o = 1'b1;
            end
            OPC_OP_32: begin
                if (RV64) fmt_o = FMT_R;
                else      illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_decode_queue.sv
// id_decode_queue: registered decode stage between fetch and issue,
// buffering decoded packets in a DEPTH-entry FIFO with flush.
module id_decode_queue
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_IFID_valid,
    output logic            o_IFID_ready,
    input  logic [XLEN-1:0] i_IFID_pc,
    input  logic [31:0]     i_IFID_inst,
    input  logic            i_IDSUE_flush,
    output logic            o_IDSUE_valid,
    input  logic            i_IDSUE_ready,
    output logic [XLEN-1:0] o_IDSUE_pc,
    output logic [6:0]      o_IDSUE_opcode,
    output logic [4:0]      o_IDSUE_rd,
    output logic [2:0]      o_IDSUE_funct3,
    output logic [4:0]      o_IDSUE_rs1,
    output logic [4:0]      o_IDSUE_rs2,
    output logic [6:0]      o_IDSUE_funct7,
    output logic [XLEN-1:0] o_IDSUE_imm,
    output logic [2:0]      o_IDSUE_fmt,
    output logic            o_IDSUE_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        id_fields_t      f;
    } pkt_t;

    pkt_t            mem_q [DEPTH];
    pkt_t            in_pkt;
    pkt_t            head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;

    id_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst_i    (i_IFID_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    assign in_pkt.pc  = i_IFID_pc;
    assign in_pkt.imm = dec_imm;
    assign in_pkt.f   = pack_fields(i_IFID_inst, dec_fmt, dec_ill);

    // Ready looks only at the registered count: no issue-to-fetch path.
    assign o_IFID_ready  = (cnt_q != CW'(DEPTH));
    assign o_IDSUE_valid = (cnt_q != '0);

    assign push = i_IFID_valid & o_IFID_ready & ~i_IDSUE_flush;
    assign pop  = o_IDSUE_valid & i_IDSUE_ready & ~i_IDSUE_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_IDSUE_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; an empty queue masks it at the outputs.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_pkt;
    end

    assign head = o_IDSUE_valid ? mem_q[rd_ptr_q] : '0;

    assign o_IDSUE_pc      = head.pc;
    assign o_IDSUE_imm     = head.imm;
    assign o_IDSUE_opcode  = head.f.opcode;
    assign o_IDSUE_rd      = head.f.rd;
    assign o_IDSUE_funct3  = head.f.funct3;
    assign o_IDSUE_rs1     = head.f.rs1;
    assign o_IDSUE_rs2     = head.f.rs2;
    assign o_IDSUE_funct7  = head.f.funct7;
    assign o_IDSUE_fmt     = head.f.fmt;
    assign o_IDSUE_illegal = head.f.illegal;

endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue: XLEN=32 and XLEN=64 queues driven in lockstep,
// compared each cycle against a queue-based reference model.
module tb_id_decode_queue;

    localparam int DEPTH = 2;

    localparam logic [6:0] OPS [13] = '{
        7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
        7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B
    };

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    ent_t q [$];

    always #5 clk = ~clk;

    id_decode_queue_if #(.XLEN(32)) b32 ();
    id_decode_queue_if #(.XLEN(64)) b64 ();

    id_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_IFID_valid    (b32.ifid_valid),
        .o_IFID_ready    (b32.ifid_ready),
        .i_IFID_pc       (b32.ifid_pc),
        .i_IFID_inst     (b32.ifid_inst),
        .i_IDSUE_flush   (b32.flush),
        .o_IDSUE_valid   (b32.idsue_valid),
        .i_IDSUE_ready   (b32.idsue_ready),
        .o_IDSUE_pc      (b32.pc),
        .o_IDSUE_opcode  (b32.opcode),
        .o_IDSUE_rd      (b32.rd),
        .o_IDSUE_funct3  (b32.funct3),
        .o_IDSUE_rs1     (b32.rs1),
        .o_IDSUE_rs2     (b32.rs2),
        .o_IDSUE_funct7  (b32.funct7),
        .o_IDSUE_imm     (b32.imm),
        .o_IDSUE_fmt     (b32.fmt),
        .o_IDSUE_illegal (b32.illegal)
    );

    id_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_IFID_valid    (b64.ifid_valid),
        .o_IFID_ready    (b64.ifid_ready),
        .i_IFID_pc       (b64.ifid_pc),
        .i_IFID_inst     (b64.ifid_inst),
        .i_IDSUE_flush   (b64.flush),
        .o_IDSUE_valid   (b64.idsue_valid),
        .i_IDSUE_ready   (b64.idsue_ready),
        .o_IDSUE_pc      (b64.pc),
        .o_IDSUE_opcode  (b64.opcode),
        .o_IDSUE_rd      (b64.rd),
        .o_IDSUE_funct3  (b64.funct3),
        .o_IDSUE_rs1     (b64.rs1),
        .o_IDSUE_rs2     (b64.rs2),
        .o_IDSUE_funct7  (b64.funct7),
        .o_IDSUE_imm     (b64.imm),
        .o_IDSUE_fmt     (b64.fmt),
        .o_IDSUE_illegal (b64.illegal)
    );

    task automatic check(input string tag,
                         input logic [191:0] got,
                         input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Immediate value built arithmetically from the bit-field weights.
    function automatic void ref_dec(input logic [31:0] w, input bit rv64,
                                    output logic [63:0] imm,
                                    output logic [2:0] fmt,
                                    output bit ill);
        longint v;
        longint n;
        v   = 0;
        fmt = 3'd1;
        ill = 1'b0;
        n   = w[31] ? -1 : 0;
        case (w[6:0])
            7'h37, 7'h17: begin
                v = n * (longint'(1) << 31) + longint'(w[30:12]) * 4096;
                fmt = 3'd4;
            end
            7'h6F: begin
                v = n * (longint'(1) << 20) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                fmt = 3'd5;
            end
            7'h63: begin
                v = n * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                fmt = 3'd3;
            end
            7'h23: begin
                v = n * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:7]);
                fmt = 3'd2;
            end
            7'h13, 7'h67, 7'h03, 7'h0F, 7'h73:
                v = n * 2048 + longint'(w[30:20]);
            7'h33: fmt = 3'd0;
            7'h1B: begin
                if (rv64) v = n * 2048 + longint'(w[30:20]);
                else      ill = 1'b1;
            end
            7'h3B: begin
                if (rv64) fmt = 3'd0;
                else      ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            v   = 0;
            fmt = 3'd1;
        end
        imm = 64'(v);
    endfunction

    function automatic logic [191:0] exp_vec(input bit rv64);
        logic [63:0] imm;
        logic [63:0] pc;
        logic [31:0] w;
        logic [2:0]  fmt;
        bit          ill;
        if (q.size() == 0) return '0;
        w  = q[0].inst;
        pc = q[0].pc;
        ref_dec(w, rv64, imm, fmt, ill);
        if (!rv64) begin
            pc  = {32'h0, pc[31:0]};
            imm = {32'h0, imm[31:0]};
        end
        return {27'h0, 1'b1, pc, w[6:0], w[11:7], w[14:12], w[19:15],
                w[24:20], w[31:25], imm, fmt, ill};
    endfunction

    function automatic logic [191:0] got32();
        return {27'h0, b32.idsue_valid, 32'h0, b32.pc, b32.opcode, b32.rd,
                b32.funct3, b32.rs1, b32.rs2, b32.funct7, 32'h0, b32.imm,
                b32.fmt, b32.illegal};
    endfunction

    function automatic logic [191:0] got64();
        return {27'h0, b64.idsue_valid, b64.pc, b64.opcode, b64.rd,
                b64.funct3, b64.rs1, b64.rs2, b64.funct7, b64.imm,
                b64.fmt, b64.illegal};
    endfunction

    task automatic check_all();
        check("pkt32", got32(), exp_vec(1'b0));
        check("pkt64", got64(), exp_vec(1'b1));
        check("rdy32", 192'(b32.ifid_ready), 192'(q.size() != DEPTH));
        check("rdy64", 192'(b64.ifid_ready), 192'(q.size() != DEPTH));
    endtask

    // Drives one cycle from a negedge, advances the model, checks at the next.
    task automatic cycle(input bit v, input logic [31:0] w,
                         input logic [63:0] pc, input bit rdy,
                         input bit fl);
        bit acc;
        b32.ifid_valid  = v;  b64.ifid_valid  = v;
        b32.ifid_inst   = w;  b64.ifid_inst   = w;
        b32.ifid_pc     = pc[31:0];
        b64.ifid_pc     = pc;
        b32.idsue_ready = rdy; b64.idsue_ready = rdy;
        b32.flush       = fl;  b64.flush       = fl;
        if (fl) begin
            q.delete();
        end else begin
            acc = v && (q.size() < DEPTH);
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back('{pc, w});
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) == 0) return r;
        return {r[31:7], OPS[$urandom_range(0, 12)]};
    endfunction

    initial begin
        logic [63:0] rpc;
        cycle_init();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        cycle(1, 32'hFFF10093, 64'h100, 1, 0);
        check("addi_imm", 192'(b32.imm), 192'(32'hFFFFFFFF));
        check("addi_rd", 192'(b32.rd), 192'(5'd1));
        check("addi_fmt", 192'(b32.fmt), 192'(3'd1));

        cycle(1, 32'hFFDFF06F, 64'h104, 1, 0);
        check("jal_imm", 192'(b32.imm), 192'(32'hFFFFFFFC));
        check("jal_fmt", 192'(b32.fmt), 192'(3'd5));
        cycle(1, 32'h00512423, 64'h108, 1, 0);
        check("sw_imm", 192'(b32.imm), 192'(32'h8));
        check("sw_rs2", 192'(b32.rs2), 192'(5'd5));
        check("sw_fmt", 192'(b32.fmt), 192'(3'd2));
        cycle(0, 32'h0, 64'h0, 1, 0);

        cycle(1, 32'h00100093, 64'h200, 0, 0);
        cycle(1, 32'h00200093, 64'h204, 0, 0);
        check("full_rdy", 192'(b32.ifid_ready), 192'(1'b0));
        cycle(1, 32'h00300093, 64'h208, 0, 0);
        cycle(1, 32'h00300093, 64'h208, 1, 0);
        check("ord_b", 192'(b32.pc), 192'(32'h204));
        cycle(1, 32'h00300093, 64'h208, 1, 0);
        check("ord_c", 192'(b32.pc), 192'(32'h208));

        cycle(1, 32'h00400093, 64'h20C, 0, 0);
        cycle(1, 32'h00500093, 64'h210, 0, 0);
        cycle(1, 32'h00600093, 64'h214, 1, 1);
        check("fl_valid", 192'(b32.idsue_valid), 192'(1'b0));
        check("fl_rdy", 192'(b32.ifid_ready), 192'(1'b1));

        cycle(1, 32'h0000003B, 64'h300, 1, 0);
        check("op32_ill32", 192'(b32.illegal), 192'(1'b1));
        check("op32_ill64", 192'(b64.illegal), 192'(1'b0));
        check("op32_fmt64", 192'(b64.fmt), 192'(3'd0));
        cycle(1, 32'h00000000, 64'h304, 1, 0);
        check("zero_ill", 192'(b32.illegal), 192'(1'b1));
        cycle(0, 32'h0, 64'h0, 1, 0);

        cycle(1, 32'h00700093, 64'h400, 0, 0);
        cycle(1, 32'h00800093, 64'h404, 0, 0);
        cycle_init();
        #2 rst_n = 1'b0;
        #1 q.delete();
        check("rst_valid", 192'(b32.idsue_valid), 192'(1'b0));
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cycle(0, 32'h0, 64'h0, 1, 0);
        cycle(0, 32'h0, 64'h0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            rpc = {$urandom(), $urandom()};
            rpc[1:0] = 2'b00;
            cycle($urandom_range(0, 3) != 0, rnd_inst(), rpc,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    task automatic cycle_init();
        b32.ifid_valid  = 1'b0; b64.ifid_valid  = 1'b0;
        b32.ifid_inst   = '0;   b64.ifid_inst   = '0;
        b32.ifid_pc     = '0;   b64.ifid_pc     = '0;
        b32.idsue_ready = 1'b0; b64.idsue_ready = 1'b0;
        b32.flush       = 1'b0; b64.flush       = 1'b0;
    endtask

endmodule

// File: doc/id_decode_queue.md
# id_decode_queue

Registered, parametrised RV32I/RV64I decode stage sitting between the fetch stage (IFID) and the issue stage (IDSUE). It accepts raw instructions over a valid/ready handshake, fully decodes each one: fields, funct7, sign-extended XLEN immediate, format class and an illegal-instruction flag. Decoded packets are held in a DEPTH-entry FIFO, so fetch and issue can stall independently. A synchronous flush discards all in-flight packets on redirect.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64 only. Sets the pc and immediate widths and enables the RV64 *W opcodes.
- DEPTH, 2: FIFO entries; power of two, 2..8.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_IFID_valid  in  1  instruction present.
- o_IFID_ready  out  1  queue can accept this cycle.
- i_IFID_pc  in  XLEN  instruction address.
- i_IFID_inst  in  32  raw instruction.
- i_IDSUE_flush  in  1  discard all queued and incoming packets.
- o_IDSUE_valid  out  1  head packet valid.
- i_IDSUE_ready  in  1  issue consumes head.
- o_IDSUE_pc  out  XLEN  packet pc.
- o_IDSUE_opcode  out  7  inst[6:0].
- o_IDSUE_rd  out  5  inst[11:7].
- o_IDSUE_funct3  out  3  inst[14:12].
- o_IDSUE_rs1  out  5  inst[19:15].
- o_IDSUE_rs2  out  5  inst[24:20].
- o_IDSUE_funct7  out  7  inst[31:25].
- o_IDSUE_imm  out  XLEN  sign-extended immediate.
- o_IDSUE_fmt  out  3  format class: R=0, I=1, S=2, B=3, U=4, J=5.
- o_IDSUE_illegal  out  1  opcode not supported.

## Operation
- Enqueue when i_IFID_valid & o_IFID_ready & !i_IDSUE_flush. The decode is computed combinationally from the inputs and written into the tail entry.
- Dequeue when o_IDSUE_valid & i_IDSUE_ready. Outputs always present the head entry.
- o_IFID_ready = (count != DEPTH). It depends only on registered count and never on i_IDSUE_ready, so there is no combinational path from issue to fetch.
- Immediate selection; every immediate is sign-extended from inst[31] to XLEN:
  - U-type (LUI, AUIPC): {inst[31:12], 12'h0}.
  - J-type (JAL): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - B-type (BRANCH): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - S-type (STORE): {inst[31:25], inst[11:7]}.
  - I-type (OP_IMM, JALR, LOAD, MISC_MEM, SYSTEM, and OP_IMM_32 when XLEN=64): inst[31:20].
  - R-type (OP, and OP_32 when XLEN=64): imm = 0; funct7 carries the function bits.
- Illegal cases: inst[1:0] != 2'b11; any opcode outside the set above; OP_IMM_32/OP_32 when XLEN=32.
- For an illegal instruction: illegal = 1, imm = 0, fmt = I. All field outputs still carry the raw bits.
- No latches: imm defaults to 0 on every path.

## Timing
- Latency 1: an instruction accepted in cycle N is valid at o_IDSUE in cycle N+1 when the queue was empty.
- Throughput 1 packet/cycle with both sides ready.
- Simultaneous enqueue and dequeue when full: the enqueue is refused, because ready was already low. The dequeue happens, and ready rises in the next cycle.
- Simultaneous enqueue and dequeue when count is 1..DEPTH-1: count is unchanged and the head advances.
- i_IDSUE_flush is synchronous and has priority over enqueue and dequeue. Next cycle: count = 0, valid = 0, ready = 1, pointers = 0.
- Asynchronous reset: count, pointers and o_IDSUE_valid clear to 0 immediately; o_IFID_ready goes to 1. All o_IDSUE data outputs read 0 while reset is asserted and while the queue is empty. Storage contents are don't-care.
- Reset asserted mid-stream drops all packets. No packet is delivered twice after release.
- Pointer width is log2(DEPTH); pointers wrap naturally at DEPTH. Count width is log2(DEPTH)+1.

## Structure
- Shared package id_pkg:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM, SYSTEM, OP_IMM_32, OP_32);
  - fmt enum;
  - decoded-packet struct, parametrised by XLEN via the top.
- Sub-module id_imm_gen: purely combinational field and immediate decoder with the XLEN parameter. It outputs imm, fmt and illegal.
- The top holds the FIFO storage, the pointers and count, the handshake, and the flush logic.

## Test plan
- XLEN=32: addi x1,x2,-1 (0xFFF10093) with issue ready. Required next cycle: valid, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, fmt=I, illegal=0.
- Back-to-back jal x0,-4 (0xFFDFF06F) then sw x5,8(x2) (0x00512423). Required: imm=0xFFFFFFFC with fmt=J, then imm=0x00000008 with fmt=S, rs2=5, rs1=2, in consecutive cycles.
- Hold i_IDSUE_ready=0 with DEPTH=2 and push 3 instructions. Required: ready drops after 2 are accepted, the third is held by fetch, and order is preserved once drained.
- Flush while full and fetch valid. Required next cycle: valid=0, ready=1, and the flushed-cycle instruction is absent from the output.
- Illegal inputs:
  - 0x0000003B (OP_32) at XLEN=32: illegal=1, imm=0.
  - The same word at XLEN=64: legal, fmt=R.
  - 0x00000000: illegal=1.
- Assert reset mid-burst with 2 packets queued. Required: valid=0 immediately, all outputs 0, and no stale packet appears after release.
